// File: rtl/oem_bisu_sorter_32x16_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oem_bisu_sorter_32x16_if : beat-level bus of the 32x16 hybrid sorter
// Rev 1.0
// ----------------------------------------------------------------------------
interface oem_bisu_sorter_32x16_if #(
  parameter int W = 6,
  parameter int P = 16
);
  logic                EN;
  logic                Vin;
  logic                INV;
  logic [P-1:0][W-1:0] DI;     // DI[0] is DI1
  logic                ENout;
  logic                Vout;
  logic [P-1:0][W-1:0] DO;     // DO[0] is DO1, first in sort order

  modport master (output EN, Vin, INV, DI, input ENout, Vout, DO);
  modport slave  (input EN, Vin, INV, DI, output ENout, Vout, DO);
endinterface
`default_nettype wire

// File: rtl/oem_bisu_sorter_32x16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oem_bisu_sorter_32x16 : per-beat odd-even merge sort, pairwise merge of two
// sorted beats into a 32-key group, streamed out as two 16-key beats.
// Rev 1.0
// ----------------------------------------------------------------------------
module oem_bisu_sorter_32x16 (
  input  logic                       clk,
  input  logic                       rst,
  oem_bisu_sorter_32x16_if.slave     bus
);
  localparam int W = 6;
  localparam int P = 16;
  localparam int N = 32;

  typedef logic [W-1:0]        key_t;
  typedef logic [P-1:0][W-1:0] beat_t;
  typedef logic [N-1:0][W-1:0] group_t;

  typedef enum logic [0:0] {
    SEQ_IDLE   = 1'b0,
    SEQ_SECOND = 1'b1
  } seq_t;

  // Batcher odd-even merge sort, ascending.
  function automatic beat_t oem_sort(input beat_t d);
    beat_t s;
    key_t  t;
    s = d;
    for (int p = 1; p < P; p = p * 2) begin
      for (int k = p; k >= 1; k = k / 2) begin
        for (int j = k % p; j <= P - 1 - k; j = j + 2 * k) begin
          for (int i = 0; i < k; i++) begin
            if ((i + j + k < P) && ((i + j) / (2 * p) == (i + j + k) / (2 * p))) begin
              if (s[i+j] > s[i+j+k]) begin
                t        = s[i+j];
                s[i+j]   = s[i+j+k];
                s[i+j+k] = t;
              end
            end
          end
        end
      end
    end
    return s;
  endfunction

  // Ascending a followed by reversed b forms a bitonic sequence; half-cleaners sort it.
  function automatic group_t bitonic_merge(input beat_t a, input beat_t b);
    group_t m;
    key_t   t;
    for (int i = 0; i < P; i++) begin
      m[i]     = a[i];
      m[N-1-i] = b[i];
    end
    for (int k = P; k >= 1; k = k / 2) begin
      for (int i = 0; i < N; i++) begin
        if ((i & k) == 0) begin
          if (m[i] > m[i+k]) begin
            t      = m[i];
            m[i]   = m[i+k];
            m[i+k] = t;
          end
        end
      end
    end
    return m;
  endfunction

  beat_t  w_oem;
  group_t w_merged;

  beat_t  r_s1;
  logic   r_v1;
  logic   r_inv1;
  beat_t  r_a;
  logic   r_inv_q;
  logic   r_held;
  group_t r_m;
  logic   r_inv_m;
  logic   r_mv;

  seq_t   r_state;
  seq_t   w_state_nxt;
  beat_t  r_do;
  beat_t  w_do_nxt;
  logic   r_vout;
  logic   w_vout_nxt;
  logic   r_en_out;

  always_comb begin
    w_oem    = oem_sort(bus.DI);
    w_merged = bitonic_merge(r_a, r_s1);
  end

  // Input stage and pairing. INV travels with the beat so the first beat's
  // value is used regardless of what is presented alongside the second beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_v1    <= 1'b0;
      r_inv1  <= 1'b0;
      r_a     <= '0;
      r_inv_q <= 1'b0;
      r_held  <= 1'b0;
      r_m     <= '0;
      r_inv_m <= 1'b0;
      r_mv    <= 1'b0;
    end else if (bus.EN) begin
      r_v1 <= bus.Vin;
      r_mv <= 1'b0;
      if (bus.Vin) begin
        r_s1   <= w_oem;
        r_inv1 <= bus.INV;
      end
      if (r_v1) begin
        if (!r_held) begin
          r_a     <= r_s1;
          r_inv_q <= r_inv1;
          r_held  <= 1'b1;
        end else begin
          r_m     <= w_merged;
          r_inv_m <= r_inv_q;
          r_held  <= 1'b0;
          r_mv    <= 1'b1;
        end
      end
    end
  end

  // Output sequencer: direction is captured with M so a following pair's
  // first beat cannot disturb the group still being streamed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEQ_IDLE;
    end else if (bus.EN) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vout_nxt  = 1'b0;
    w_do_nxt    = r_do;
    case (r_state)
      SEQ_IDLE: begin
        if (r_mv) begin
          w_vout_nxt  = 1'b1;
          w_state_nxt = SEQ_SECOND;
          for (int i = 0; i < P; i++) begin
            w_do_nxt[i] = r_inv_m ? r_m[N-1-i] : r_m[i];
          end
        end
      end
      SEQ_SECOND: begin
        w_vout_nxt  = 1'b1;
        w_state_nxt = SEQ_IDLE;
        for (int i = 0; i < P; i++) begin
          w_do_nxt[i] = r_inv_m ? r_m[P-1-i] : r_m[P+i];
        end
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_do     <= '0;
      r_vout   <= 1'b0;
      r_en_out <= 1'b0;
    end else begin
      r_en_out <= bus.EN;
      if (bus.EN) begin
        r_do   <= w_do_nxt;
        r_vout <= w_vout_nxt;
      end
    end
  end

  assign bus.DO    = r_do;
  assign bus.Vout  = r_vout;
  assign bus.ENout = r_en_out;

endmodule
`default_nettype wire

// File: tb/tb_oem_bisu_sorter_32x16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_oem_bisu_sorter_32x16 : directed self-checking bench for the 32x16 sorter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_oem_bisu_sorter_32x16;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  oem_bisu_sorter_32x16_if #(.W(6), .P(16)) bus ();

  oem_bisu_sorter_32x16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mix_a [16] = '{50,43,14,37,21,25,60,7,56,30,44,49,3,39,18,63};
  int mix_b [16] = '{7,13,19,24,10,22,29,5,12,17,27,2,15,20,9,18};
  int asc1  [16] = '{2,3,5,7,7,9,10,12,13,14,15,17,18,18,19,20};
  int asc2  [16] = '{21,22,24,25,27,29,30,37,39,43,44,49,50,56,60,63};
  int dsc1  [16] = '{63,60,56,50,49,44,43,39,37,30,29,27,25,24,22,21};
  int dsc2  [16] = '{20,19,18,18,17,15,14,13,12,10,9,7,7,5,3,2};
  int zeros [16];
  int max63 [16];

  function automatic logic [95:0] pk(input int k [16]);
    logic [95:0] r;
    logic [31:0] v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v = k[i];
      r[95-6*i -: 6] = v[5:0];
    end
    return r;
  endfunction

  function automatic logic [95:0] obs_do();
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[95-6*i -: 6] = bus.DO[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k [16], input logic inv);
    logic [31:0] v;
    bus.Vin = 1'b1;
    bus.INV = inv;
    for (int i = 0; i < 16; i++) begin
      v = k[i];
      bus.DI[i] = v[5:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Vin = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) begin
      zeros[i] = 0;
      max63[i] = 63;
    end
    rst     = 1'b0;
    bus.EN  = 1'b1;
    bus.Vin = 1'b0;
    bus.INV = 1'b0;
    bus.DI  = '0;

    // Reset state
    #12;
    chk("reset_do",    obs_do(),  '0);
    chk("reset_vout",  96'(bus.Vout),  96'(0));
    chk("reset_enout", 96'(bus.ENout), 96'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("enout_run", 96'(bus.ENout), 96'(1));

    // Mixed pair, ascending
    send(mix_a, 1'b0);
    send(mix_b, 1'b0);
    idle();
    chk("asc_t1_vout", 96'(bus.Vout), 96'(0));
    idle();
    chk("asc_beat1",      obs_do(), pk(asc1));
    chk("asc_beat1_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("asc_beat2",      obs_do(), pk(asc2));
    chk("asc_beat2_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("asc_t4_vout", 96'(bus.Vout), 96'(0));
    chk("asc_do_hold", obs_do(), pk(asc2));

    // Reset mid-pair: held beat must be discarded
    send(max63, 1'b0);
    bus.Vin = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_do",    obs_do(), '0);
    chk("midrst_vout",  96'(bus.Vout),  96'(0));
    chk("midrst_enout", 96'(bus.ENout), 96'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Mixed pair, descending (INV only on first beat)
    send(mix_a, 1'b1);
    send(mix_b, 1'b0);
    idle();
    idle();
    chk("dsc_beat1",      obs_do(), pk(dsc1));
    chk("dsc_beat1_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("dsc_beat2",      obs_do(), pk(dsc2));
    idle();
    chk("dsc_t4_vout", 96'(bus.Vout), 96'(0));

    // Extremes back-to-back with the mixed pair
    send(zeros, 1'b0);
    send(max63, 1'b0);
    send(mix_a, 1'b0);
    send(mix_b, 1'b0);
    chk("b2b_zero",      obs_do(), pk(zeros));
    chk("b2b_zero_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("b2b_max",      obs_do(), pk(max63));
    chk("b2b_max_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("b2b_mix1",      obs_do(), pk(asc1));
    chk("b2b_mix1_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("b2b_mix2",      obs_do(), pk(asc2));
    chk("b2b_mix2_vout", 96'(bus.Vout), 96'(1));
    idle();
    chk("b2b_end_vout", 96'(bus.Vout), 96'(0));

    // Vin gaps between the two beats of a pair
    send(mix_a, 1'b1);
    idle();
    idle();
    idle();
    send(mix_b, 1'b0);
    chk("gap_t0_vout", 96'(bus.Vout), 96'(0));
    idle();
    chk("gap_t1_vout", 96'(bus.Vout), 96'(0));
    idle();
    chk("gap_beat1", obs_do(), pk(dsc1));
    idle();
    chk("gap_beat2", obs_do(), pk(dsc2));

    // EN stall between the two output beats
    send(mix_a, 1'b0);
    send(mix_b, 1'b0);
    idle();
    idle();
    chk("stall_beat1", obs_do(), pk(asc1));
    chk("stall_pre_enout", 96'(bus.ENout), 96'(1));
    bus.EN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("stall_do",    obs_do(), pk(asc1));
      chk("stall_vout",  96'(bus.Vout),  96'(1));
      chk("stall_enout", 96'(bus.ENout), 96'(0));
    end
    bus.EN = 1'b1;
    idle();
    chk("stall_beat2",      obs_do(), pk(asc2));
    chk("stall_beat2_vout", 96'(bus.Vout),  96'(1));
    chk("stall_post_enout", 96'(bus.ENout), 96'(1));
    idle();
    chk("stall_end_vout", 96'(bus.Vout), 96'(0));
    chk("stall_end_do",   obs_do(), pk(asc2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/oem_bisu_sorter_32x16.md
# oem_bisu_sorter_32x16

Pipelined hybrid sorter for N=32 six-bit keys delivered as two parallel beats of P=16. Each beat is sorted by a 16-input Batcher odd-even merge network (OEM). The bidirectional insertion/merge unit (BISU) then merges each pair of sorted beats into one 32-key sorted sequence. The result is streamed out as two consecutive 16-key beats. The block sits between the parallel data source and any downstream consumer needing fully ordered 32-key groups.

## Interface
- W, 6: key width in bits.
- P, 16: keys per beat; fixed lane count.
- N, 32: keys per sorted group (2 beats).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- EN  in  1  global enable; 0 stalls every register (hold).
- Vin  in  1  input beat valid; beat accepted on a rising edge with EN=1 and Vin=1.
- INV  in  1  order select, sampled with the first beat of a pair: 0 ascending, 1 descending.
- DI1..DI16  in  W each  input keys of the beat, unsigned.
- ENout  out  1  EN registered one cycle (registered even when EN=0).
- Vout  out  1  output beat valid.
- DO1..DO16  out  W each  output keys; DO1 is first in sort order.

## Operation
- OEM stage: combinational 16-input odd-even merge sort (63 compare-exchange units, 10 levels) on DI1..DI16, always ascending, unsigned compare. Ties keep either value; only the multiset matters.
- Result registered into S1 with valid v1 on an accepting edge; v1 clears on an edge with EN=1 and Vin=0.
- BISU pairing: flag `held`.
  - v1=1 and held=0: S1 is copied to register A, INV is copied to inv_q, and held is set.
  - v1=1 and held=1: A and S1 are merged into a 32-key ascending register M, held is cleared, and the output sequencer starts.
- Merge method is free, e.g. a bidirectional merge taking the min from the fronts and the max from the backs simultaneously, or a bitonic merge of A with reversed S1.
- Output sequencer:
  - First beat: DO = M[0..15] if inv_q=0, else M[31..16] (largest first).
  - Second beat: the remaining 16 keys in the same direction.
  - Vout=1 for exactly those two beats.
- INV presented with the second beat of a pair is ignored.
- Keys are unsigned. No arithmetic beyond comparison; no width growth.

## Timing
- Reset (rst=0, asynchronous): S1, A, M, DO1..DO16 = 0; v1, held, inv_q, Vout, ENout = 0.
  - Reset mid-pair discards the held beat. The first accepted beat after release is a new first beat.
- Let t be the edge accepting the second beat of a pair; all counts assume EN=1.
  - Edge t: S1 loaded.
  - Edge t+1: M loaded.
  - Edge t+2: first output beat registered, Vout=1.
  - Edge t+3: second output beat registered, Vout=1.
  - Edge t+4: Vout=0 unless the next pair's first beat is due.
- Maximum throughput: one beat per cycle, so one group every 2 cycles; output beats are then back-to-back with Vout continuously 1. No back-pressure and no overflow case exists.
- EN=0:
  - All state holds and no beat is accepted.
  - Vout and DO hold their values; ENout goes 0 one edge later.
  - An output beat pair split by a stall resumes with the second beat when EN returns.
- DO retains the last output beat while Vout=0.

## Test plan
- Reset: assert rst=0 mid-stream -> all DO=0, Vout=0, ENout=0 immediately. Then release and send 2 beats -> correct group; any beat held before reset is discarded.
- Mixed data, INV=0:
  - Beat A {50,43,14,37,21,25,60,7,56,30,44,49,3,39,18,63}, then beat B {7,13,19,24,10,22,29,5,12,17,27,2,15,20,9,18}.
  - Edge t+2: DO1..16 = 2,3,5,7,7,9,10,12,13,14,15,17,18,18,19,20.
  - Edge t+3: 21,22,24,25,27,29,30,37,39,43,44,49,50,56,60,63.
- Same beats with INV=1 on beat A -> first output beat 63,60,56,50,49,44,43,39,37,30,29,27,25,24,22,21; second output beat 20,19,18,18,17,15,14,13,12,10,9,7,7,5,3,2.
- Extremes, back-to-back: pair all-0 / all-63 immediately followed by the mixed pair -> outputs all 0, then all 63, then the mixed results; Vout high 4 consecutive cycles.
- Gaps and stalls:
  - Vin=0 cycles between beat A and beat B -> identical result, latency counted from beat B.
  - EN=0 for 3 cycles between the two output beats -> DO and Vout frozen, the second output beat appears after EN returns, and ENout tracks EN delayed one cycle.
